pipe_elastic_buf: RTL and testbench

- Parametrised elastic pipeline buffer for inter-stage registers: generalises the fixed enable-only stage buffers to a DEPTH-entry queue with a valid/ready handshake, flush and occupancy reporting.
- Sits between any two pipeline stages, for example fetch→decode or mem→writeback.
- Lets a downstream stall back-pressure the upstream stage without losing or duplicating a packet.

---
 rtl/pipe_elastic_buf.sv | 98 +++++++++
 tb/tb_pipe_elastic_buf.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_elastic_buf.sv
// pipe_elastic_buf: DEPTH-entry elastic buffer between two pipeline stages.
// Define PIPE_ELASTIC_BUF_STATS_EN to build the o_stall_cnt statistic.
module pipe_elastic_buf #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_count,
    output logic [15:0]       o_stall_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  count;
    logic              doPush;
    logic              doPop;

    // Pointer advance wraps explicitly so non power-of-two depths work.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake flags come only from registered occupancy.
    assign o_ready = (count < FULL);
    assign o_valid = (count != '0);
    assign o_data  = mem[rdPtr];
    assign o_count = count;
    assign doPush  = i_valid && o_ready;
    assign doPop   = o_valid && i_ready;

    // Storage: cleared by reset, left untouched by flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (doPush && !i_flush) begin
            mem[wrPtr] <= i_data;
        end
    end

    // Pointers and occupancy; flush rewinds and drops this cycle's transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (i_flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= nextPtr(wrPtr);
            end
            if (doPop) begin
                rdPtr <= nextPtr(rdPtr);
            end
            unique case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef PIPE_ELASTIC_BUF_STATS_EN
    logic [15:0] stallCnt;

    // Saturating count of cycles the head packet is held by downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt <= '0;
        end else if (o_valid && !i_ready && stallCnt != 16'hFFFF) begin
            stallCnt <= stallCnt + 16'd1;
        end
    end

    assign o_stall_cnt = stallCnt;
`else
    assign o_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_elastic_buf.sv
// tb_pipe_elastic_buf: queue scoreboard across DEPTH=2,3,4 instances.
// Directed streams for stream, backpressure, wrap, flush, reset, stats.
module tb_pipe_elastic_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iFlush [3];
    logic        iValid [3];
    logic        iReady [3];
    logic [15:0] iData  [3];
    logic        oValid [3];
    logic        oReady [3];
    logic [15:0] oData  [3];
    logic [4:0]  oCount [3];
    logic [15:0] oStall [3];

    int checks = 0;
    int failures = 0;
    int maxCnt [3];
    int beefSeen = 0;
    logic [15:0] seen0 [$];
    logic [15:0] seen1 [$];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 3; g++) begin : gInst
        localparam int D = (g == 0) ? 2 : (g == 1) ? 3 : 4;
        localparam int CW = $clog2(D + 1);
        logic [CW-1:0] cnt;
        logic [15:0] expQ [$];
        int mStall = 0;
        bit doPush;
        bit doPop;

        pipe_elastic_buf #(.DATA_W(16), .DEPTH(D)) dut (
            .clk(clk),
            .rst(rst),
            .i_flush(iFlush[g]),
            .i_valid(iValid[g]),
            .o_ready(oReady[g]),
            .i_data(iData[g]),
            .o_valid(oValid[g]),
            .i_ready(iReady[g]),
            .o_data(oData[g]),
            .o_count(cnt),
            .o_stall_cnt(oStall[g])
        );

        assign oCount[g] = 5'(cnt);

        // reference queue: accepted packets in order, flushed on redirect
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                expQ.delete();
                mStall = 0;
            end else begin
`ifdef PIPE_ELASTIC_BUF_STATS_EN
                if (expQ.size() != 0 && !iReady[g] && mStall < 65535)
                    mStall++;
`endif
                doPop = iReady[g] && expQ.size() != 0;
                doPush = iValid[g] && expQ.size() < D;
                if (iFlush[g]) begin
                    expQ.delete();
                end else begin
                    if (doPop) void'(expQ.pop_front());
                    if (doPush) expQ.push_back(iData[g]);
                end
            end
        end

        // monitor: compare head and flags against the reference each cycle
        always @(negedge clk) begin
            if (rst) begin
                chk($sformatf("u%0d.count", g), oCount[g], expQ.size());
                chk($sformatf("u%0d.valid", g), oValid[g], expQ.size() != 0);
                chk($sformatf("u%0d.ready", g), oReady[g], expQ.size() < D);
                chk($sformatf("u%0d.stall", g), oStall[g], mStall);
                if (oValid[g] && expQ.size() != 0)
                    chk($sformatf("u%0d.data", g), oData[g], expQ[0]);
                if (int'(oCount[g]) > maxCnt[g]) maxCnt[g] = int'(oCount[g]);
                if (oValid[g] && iReady[g]) begin
                    if (g == 0) seen0.push_back(oData[g]);
                    if (g == 1) seen1.push_back(oData[g]);
                    if (g == 2 && oData[g] == 16'hBEEF) beefSeen++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        bit sent;
        int k;
        int stallExp5;
        int stallExp8;
        for (int g = 0; g < 3; g++) begin
            iFlush[g] = 1'b0;
            iValid[g] = 1'b0;
            iReady[g] = 1'b0;
            iData[g] = '0;
            maxCnt[g] = 0;
        end
        #1;
        chk("rst.valid", oValid[0], 0);
        chk("rst.ready", oReady[0], 1);
        chk("rst.data", oData[0], 0);
        chk("rst.count", oCount[0], 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // basic stream on DEPTH=2
        iReady[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iValid[0] = 1'b1;
            iData[0] = 16'hA001 + 16'(i);
            tick();
            chk("basic.data", oData[0], 16'hA001 + i);
            chk("basic.count", oCount[0], 1);
            chk("basic.ready", oReady[0], 1);
        end
        iValid[0] = 1'b0;
        tick();
        chk("basic.drain", oCount[0], 0);

        // backpressure on DEPTH=2
        seen0.delete();
        iReady[0] = 1'b0;
        iValid[0] = 1'b1;
        iData[0] = 16'hA001;
        tick();
        iData[0] = 16'hA002;
        tick();
        chk("bp.count", oCount[0], 2);
        chk("bp.ready", oReady[0], 0);
        iData[0] = 16'hA003;
        tick();
        tick();
        chk("bp.hold", oCount[0], 2);
        chk("bp.head", oData[0], 16'hA001);
        iReady[0] = 1'b1;
        sent = 1'b0;
        for (int c = 0; c < 10 && !sent; c++) begin
            acc = oReady[0];
            tick();
            if (acc) begin
                sent = 1'b1;
                iValid[0] = 1'b0;
            end
        end
        iValid[0] = 1'b0;
        repeat (4) tick();
        chk("bp.n", seen0.size(), 3);
        for (int i = 0; i < 3 && i < seen0.size(); i++)
            chk("bp.order", seen0[i], 16'hA001 + i);

        // wrap-around on DEPTH=3
        seen1.delete();
        maxCnt[1] = 0;
        k = 0;
        for (int c = 0; c < 100 && k < 10; c++) begin
            iValid[1] = 1'b1;
            iData[1] = 16'(k);
            iReady[1] = (c % 2 == 0);
            acc = oReady[1];
            tick();
            if (acc) k++;
        end
        iValid[1] = 1'b0;
        iReady[1] = 1'b1;
        repeat (6) tick();
        chk("wrap.n", seen1.size(), 10);
        for (int i = 0; i < 10 && i < seen1.size(); i++)
            chk("wrap.order", seen1[i], i);
        chk("wrap.max", maxCnt[1], 3);

        // flush on DEPTH=4
        iReady[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iValid[2] = 1'b1;
            iData[2] = 16'hC001 + 16'(i);
            tick();
        end
        chk("fl.count", oCount[2], 3);
        iFlush[2] = 1'b1;
        iData[2] = 16'hBEEF;
        iReady[2] = 1'b1;
        tick();
        iFlush[2] = 1'b0;
        iValid[2] = 1'b0;
        chk("fl.valid", oValid[2], 0);
        chk("fl.count0", oCount[2], 0);
        chk("fl.ready", oReady[2], 1);
        repeat (3) tick();
        iValid[2] = 1'b1;
        iData[2] = 16'hC004;
        tick();
        iValid[2] = 1'b0;
        chk("fl.after", oData[2], 16'hC004);
        tick();
        chk("fl.beef", beefSeen, 0);

        // asynchronous reset with DEPTH=2 full
        iReady[0] = 1'b0;
        iValid[0] = 1'b1;
        iData[0] = 16'h1111;
        tick();
        iData[0] = 16'h2222;
        tick();
        iValid[0] = 1'b0;
        chk("ar.full", oCount[0], 2);
        #1 rst = 1'b0;
        #1;
        chk("ar.valid", oValid[0], 0);
        chk("ar.count", oCount[0], 0);
        chk("ar.data", oData[0], 0);
        chk("ar.ready", oReady[0], 1);
        chk("ar.stall", oStall[0], 0);
        rst = 1'b1;
        tick();
        iValid[0] = 1'b1;
        iData[0] = 16'h1234;
        tick();
        iValid[0] = 1'b0;
        chk("ar.push", oData[0], 16'h1234);
        chk("ar.pv", oValid[0], 1);
        iReady[0] = 1'b1;
        tick();
        chk("ar.drain", oCount[0], 0);

        // stall statistic
`ifdef PIPE_ELASTIC_BUF_STATS_EN
        stallExp5 = 5;
        stallExp8 = 8;
`else
        stallExp5 = 0;
        stallExp8 = 0;
`endif
        iReady[0] = 1'b0;
        iValid[0] = 1'b1;
        iData[0] = 16'h5555;
        tick();
        iValid[0] = 1'b0;
        repeat (5) tick();
        chk("st.five", oStall[0], stallExp5);
        iFlush[0] = 1'b1;
        iReady[0] = 1'b1;
        tick();
        iFlush[0] = 1'b0;
        iReady[0] = 1'b0;
        iValid[0] = 1'b1;
        iData[0] = 16'h6666;
        tick();
        iValid[0] = 1'b0;
        repeat (3) tick();
        chk("st.eight", oStall[0], stallExp8);
        iReady[0] = 1'b1;
        tick();
        chk("st.keep", oStall[0], stallExp8);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
